// File: rtl/mem_arbiter_if.sv
// Bundle of loader, fetch and debug request ports plus the memory-controller side.
// The arbiter uses the slave view; the surrounding system drives through the master view.
interface mem_arbiter_if;
    logic        ld_req;
    logic        ld_wren;
    logic        ld_done;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        f_req;
    logic        f_wren;
    logic [31:0] f_addr;
    logic [31:0] f_wdata;
    logic        d_req;
    logic        d_wren;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ld_gnt;
    logic        f_gnt;
    logic        d_gnt;
    logic        f_rvalid;
    logic        d_rvalid;
    logic [31:0] f_rdata;
    logic [31:0] d_rdata;
    logic        f_stall;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_wren;
    logic [31:0] mem_data_out;
    logic        run;
    logic [1:0]  owner;

    modport slave (
        input  ld_req, ld_wren, ld_done, ld_addr, ld_wdata,
        input  f_req, f_wren, f_addr, f_wdata,
        input  d_req, d_wren, d_addr, d_wdata,
        input  mem_data_out,
        output ld_gnt, f_gnt, d_gnt, f_rvalid, d_rvalid, f_rdata, d_rdata,
        output f_stall, mem_address, mem_data_in, mem_wren, run, owner
    );

    modport master (
        output ld_req, ld_wren, ld_done, ld_addr, ld_wdata,
        output f_req, f_wren, f_addr, f_wdata,
        output d_req, d_wren, d_addr, d_wdata,
        output mem_data_out,
        input  ld_gnt, f_gnt, d_gnt, f_rvalid, d_rvalid, f_rdata, d_rdata,
        input  f_stall, mem_address, mem_data_in, mem_wren, run, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loader owns memory until ld_done, then fetch and debug
// share it with fetch favoured for up to FETCH_BURST back-to-back grants.
module mem_arbiter #(
    parameter int FETCH_BURST = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(FETCH_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(FETCH_BURST);

    typedef enum logic {PH_LOAD, PH_RUN} phase_e;
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_LD   = 2'b01,
        OWN_F    = 2'b10,
        OWN_D    = 2'b11
    } owner_e;

    phase_e          phase_q, phase_d;
    logic            last_dbg_q, last_dbg_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            f_rvalid_q, f_rvalid_d;
    logic            d_rvalid_q, d_rvalid_d;
    owner_e          owner;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= PH_LOAD;
            last_dbg_q  <= 1'b1;
            burst_cnt_q <= '0;
            f_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            last_dbg_q  <= last_dbg_d;
            burst_cnt_q <= burst_cnt_d;
            f_rvalid_q  <= f_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        owner       = OWN_NONE;
        last_dbg_d  = last_dbg_q;
        burst_cnt_d = burst_cnt_q;

        case (phase_q)
            PH_LOAD: begin
                if (bus.ld_done) phase_d = PH_RUN;
                if (bus.ld_req)  owner   = OWN_LD;
            end
            PH_RUN: begin
                // Contention: fetch keeps the port until its burst allowance is used up.
                if (bus.f_req && bus.d_req)
                    owner = (last_dbg_q || (burst_cnt_q < BURST_MAX)) ? OWN_F : OWN_D;
                else if (bus.f_req)
                    owner = OWN_F;
                else if (bus.d_req)
                    owner = OWN_D;
            end
            default: phase_d = PH_LOAD;
        endcase

        if (!reset_n) owner = OWN_NONE;

        if (owner == OWN_F) last_dbg_d = 1'b0;
        if (owner == OWN_D) last_dbg_d = 1'b1;

        if (!bus.d_req || owner == OWN_D)
            burst_cnt_d = '0;
        else if (owner == OWN_F && burst_cnt_q < BURST_MAX)
            burst_cnt_d = burst_cnt_q + CW'(1);

        f_rvalid_d = (owner == OWN_F) && !bus.f_wren;
        d_rvalid_d = (owner == OWN_D) && !bus.d_wren;
    end

    always_comb begin
        bus.mem_address = '0;
        bus.mem_data_in = '0;
        bus.mem_wren    = 1'b0;
        case (owner)
            OWN_LD: begin
                bus.mem_address = bus.ld_addr;
                bus.mem_data_in = bus.ld_wdata;
                bus.mem_wren    = bus.ld_wren;
            end
            OWN_F: begin
                bus.mem_address = bus.f_addr;
                bus.mem_data_in = bus.f_wdata;
                bus.mem_wren    = bus.f_wren;
            end
            OWN_D: begin
                bus.mem_address = bus.d_addr;
                bus.mem_data_in = bus.d_wdata;
                bus.mem_wren    = bus.d_wren;
            end
            default: ;
        endcase
    end

    assign bus.ld_gnt   = (owner == OWN_LD);
    assign bus.f_gnt    = (owner == OWN_F);
    assign bus.d_gnt    = (owner == OWN_D);
    assign bus.owner    = owner;
    assign bus.run      = (phase_q == PH_RUN);
    assign bus.f_stall  = (bus.f_req && (owner != OWN_F)) || (phase_q == PH_LOAD);
    assign bus.f_rvalid = f_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.f_rdata  = bus.mem_data_out;
    assign bus.d_rdata  = bus.mem_data_out;
endmodule
